// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared types and elaboration helpers for the paddle controller
//
// Contents:
//   paddle_state_t  per-channel FSM state encoding (IDLE, UP, DN)
//   calc_maxc       highest legal coordinate: visible range minus paddle height
//   calc_center     recenter/reset coordinate: half of MAXC, rounded down
//   clog2           counter width helper (minimum width 1)

package paddle_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DN   = 2'd2
   } paddle_state_t;

   function automatic int calc_maxc(input int vis_lines, input int pad_lines);
      return vis_lines - pad_lines;
   endfunction

   function automatic int calc_center(input int maxc);
      return maxc / 2;
   endfunction

   // Bits needed to count 0..n-1; never returns less than 1 so a
   // degenerate count still yields a legal vector.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/paddle_axis.sv
// rtl/paddle_axis.sv - one paddle channel: synchronizer, FSM, step/hold logic, coordinate
//
// Optional feature macro: PADDLE_ACCEL_EN (hold-to-accelerate step/hold registers).
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   tick      in   one-cycle movement strobe shared by all channels
//   recenter  in   synchronous return to CENTER, highest priority
//   btn_up    in   debounced up level (asynchronous to clk)
//   btn_dn    in   debounced down level (asynchronous to clk)
//   coord     out  registered vertical coordinate, 0..MAXC
//   moving    out  FSM state is not IDLE
//   at_limit  out  coord is 0 or MAXC

module paddle_axis #(
   parameter int CW         = 9,
   parameter int RANGE      = 480,
   parameter int PH         = 75,
   parameter int STEP       = 1,
   parameter int MAXSTEP    = 4,
   parameter int HOLD_TICKS = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          recenter,
   input  logic          btn_up,
   input  logic          btn_dn,
   output logic [CW-1:0] coord,
   output logic          moving,
   output logic          at_limit
);

   import paddle_pkg::*;

   localparam int MAXC   = calc_maxc(RANGE, PH);
   localparam int CENTER = calc_center(MAXC);
   localparam int SW     = clog2(MAXSTEP + 1);

   localparam logic [CW:0]   MAXC_X   = (CW+1)'(MAXC);
   localparam logic [CW-1:0] MAXC_C   = CW'(MAXC);
   localparam logic [CW-1:0] CENTER_C = CW'(CENTER);
   localparam logic [SW-1:0] STEP_S   = SW'(STEP);

   if (MAXC < 1 || MAXC >= (1 << CW)) begin : g_bad_maxc
      $error("paddle_axis: RANGE-PH must be positive and fit in CW bits");
   end
   if (STEP < 1 || STEP > MAXSTEP) begin : g_bad_step
      $error("paddle_axis: STEP must lie in 1..MAXSTEP");
   end
   if (HOLD_TICKS < 1) begin : g_bad_hold
      $error("paddle_axis: HOLD_TICKS must be at least 1");
   end

   // ---------------------------------------------------------------
   // Two-flop synchronizers for the button levels
   // ---------------------------------------------------------------
   logic [1:0] up_sync;
   logic [1:0] dn_sync;
   logic       up_s;
   logic       dn_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         up_sync <= 2'b00;
         dn_sync <= 2'b00;
      end else begin
         up_sync <= {up_sync[0], btn_up};
         dn_sync <= {dn_sync[0], btn_dn};
      end
   end

   assign up_s = up_sync[1];
   assign dn_s = dn_sync[1];

   // ---------------------------------------------------------------
   // FSM: state register / next-state / outputs
   // ---------------------------------------------------------------
   paddle_state_t state;
   paddle_state_t state_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (up_s && !dn_s)      state_nxt = UP;
            else if (dn_s && !up_s) state_nxt = DN;
         end
         UP: begin
            if (dn_s && !up_s)        state_nxt = DN;
            else if (!(up_s && !dn_s)) state_nxt = IDLE;
         end
         DN: begin
            if (up_s && !dn_s)        state_nxt = UP;
            else if (!(dn_s && !up_s)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (recenter) state_nxt = IDLE;
   end

   always_comb begin
      moving = (state != IDLE);
   end

   // ---------------------------------------------------------------
   // Step size (constant unless acceleration is compiled in)
   // ---------------------------------------------------------------
   logic [SW-1:0] step_q;

`ifdef PADDLE_ACCEL_EN
   localparam int HW = clog2(HOLD_TICKS);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [SW-1:0] MAXSTEP_S = SW'(MAXSTEP);

   logic [HW-1:0] hold_q;
   logic          enter;

   // Any entry into UP or DN (including a direct reversal) restarts the
   // acceleration ramp from the base step.
   assign enter = (state_nxt != state) && (state_nxt != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_q <= STEP_S;
         hold_q <= '0;
      end else if (recenter || enter) begin
         step_q <= STEP_S;
         hold_q <= '0;
      end else if (tick && state != IDLE) begin
         // The move on this tick uses the old step; the increment applies
         // from the next tick onward.
         if (hold_q == HOLD_LAST) begin
            hold_q <= '0;
            if (step_q < MAXSTEP_S) step_q <= step_q + SW'(1);
         end else begin
            hold_q <= hold_q + HW'(1);
         end
      end
   end
`else
   assign step_q = STEP_S;
`endif

   // ---------------------------------------------------------------
   // Saturating coordinate update, one guard bit for over/underflow
   // ---------------------------------------------------------------
   logic [CW:0]   step_x;
   logic [CW:0]   up_sum;
   logic [CW:0]   dn_dif;
   logic [CW-1:0] up_sat;
   logic [CW-1:0] dn_sat;
   logic [CW-1:0] coord_q;

   always_comb begin
      step_x = (CW+1)'(step_q);
      up_sum = {1'b0, coord_q} + step_x;
      dn_dif = {1'b0, coord_q} - step_x;
      up_sat = (up_sum > MAXC_X) ? MAXC_C : up_sum[CW-1:0];
      dn_sat = dn_dif[CW] ? '0 : dn_dif[CW-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         coord_q <= CENTER_C;
      end else if (recenter) begin
         coord_q <= CENTER_C;
      end else if (tick) begin
         case (state)
            UP:      coord_q <= up_sat;
            DN:      coord_q <= dn_sat;
            default: coord_q <= coord_q;
         endcase
      end
   end

   assign coord    = coord_q;
   assign at_limit = (coord_q == '0) || (coord_q == MAXC_C);

endmodule

// File: rtl/paddle_ctrl_multi.sv
// rtl/paddle_ctrl_multi.sv - multi-channel saturating paddle position controller
//
// Optional feature macro: PADDLE_ACCEL_EN (hold-to-accelerate, built in paddle_axis).
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   enable    in   global run; low freezes tick counter and coordinates
//   btn_up    in   [NCH] debounced up levels
//   btn_dn    in   [NCH] debounced down levels
//   recenter  in   synchronous return of all paddles to CENTER
//   coord     out  [NCH*CW] packed coordinates, channel i at [i*CW +: CW]
//   moving    out  [NCH] channel FSM not IDLE
//   at_limit  out  [NCH] channel coordinate at 0 or MAXC

module paddle_ctrl_multi #(
   parameter int NCH        = 2,
   parameter int CW         = 9,
   parameter int RANGE      = 480,
   parameter int PH         = 75,
   parameter int STEP       = 1,
   parameter int MAXSTEP    = 4,
   parameter int HOLD_TICKS = 16,
   parameter int TICK_DIV   = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [NCH-1:0]    btn_up,
   input  logic [NCH-1:0]    btn_dn,
   input  logic              recenter,
   output logic [NCH*CW-1:0] coord,
   output logic [NCH-1:0]    moving,
   output logic [NCH-1:0]    at_limit
);

   import paddle_pkg::*;

   localparam int TW = clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   if (TICK_DIV < 1 || NCH < 1) begin : g_bad_cfg
      $error("paddle_ctrl_multi: TICK_DIV and NCH must be at least 1");
   end

   // Movement tick shared by all channels; frozen (not cleared) while
   // enable is low so a paused count resumes where it stopped.
   logic [TW-1:0] tick_cnt;
   logic          tick;

   assign tick = enable && (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (enable) begin
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      paddle_axis #(
         .CW         (CW),
         .RANGE      (RANGE),
         .PH         (PH),
         .STEP       (STEP),
         .MAXSTEP    (MAXSTEP),
         .HOLD_TICKS (HOLD_TICKS)
      ) u_axis (
         .clk      (clk),
         .reset    (reset),
         .tick     (tick),
         .recenter (recenter),
         .btn_up   (btn_up[i]),
         .btn_dn   (btn_dn[i]),
         .coord    (coord[i*CW +: CW]),
         .moving   (moving[i]),
         .at_limit (at_limit[i])
      );
   end

endmodule

// File: tb/tb_paddle_ctrl_multi.sv
// tb/tb_paddle_ctrl_multi.sv - scoreboard bench for paddle_ctrl_multi (TICK_DIV=4)

module tb_paddle_ctrl_multi;

   localparam int NCH = 2;
   localparam int CW  = 9;

   logic              clk;
   logic              reset;
   logic              enable;
   logic [NCH-1:0]    btn_up;
   logic [NCH-1:0]    btn_dn;
   logic              recenter;
   logic [NCH*CW-1:0] coord;
   logic [NCH-1:0]    moving;
   logic [NCH-1:0]    at_limit;

   paddle_ctrl_multi #(
      .NCH        (NCH),
      .CW         (CW),
      .RANGE      (480),
      .PH         (75),
      .STEP       (1),
      .MAXSTEP    (4),
      .HOLD_TICKS (4),
      .TICK_DIV   (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .btn_up   (btn_up),
      .btn_dn   (btn_dn),
      .recenter (recenter),
      .coord    (coord),
      .moving   (moving),
      .at_limit (at_limit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc == k at the negedge following the k-th rising edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int    due;
      int    kind;   // 0 coord[ch], 1 moving vector, 2 at_limit vector
      int    ch;
      int    expv;
      string name;
   } exp_t;

   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   task automatic push(input int due, input int kind, input int ch, input int expv, input string name);
      exp_t e;
      e.due  = due;
      e.kind = kind;
      e.ch   = ch;
      e.expv = expv;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic exp_coord(input int due, input int c0, input int c1, input string name);
      push(due, 0, 0, c0, {name, ".coord0"});
      push(due, 0, 1, c1, {name, ".coord1"});
   endtask

   task automatic exp_mov(input int due, input int v, input string name);
      push(due, 1, 0, v, {name, ".moving"});
   endtask

   task automatic exp_lim(input int due, input int v, input string name);
      push(due, 2, 0, v, {name, ".at_limit"});
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Monitor: compares every expectation whose cycle has come
   int mi;
   int act;
   always @(negedge clk) begin
      mi = 0;
      while (mi < sb.size()) begin
         if (sb[mi].due <= cyc) begin
            case (sb[mi].kind)
               0:       act = int'(coord[sb[mi].ch*CW +: CW]);
               1:       act = int'(moving);
               default: act = int'(at_limit);
            endcase
            n_run++;
            if (act != sb[mi].expv) begin
               n_fail++;
               $display("FAIL %s @cyc %0d: got %0d, expected %0d", sb[mi].name, cyc, act, sb[mi].expv);
            end
            sb.delete(mi);
         end else begin
            mi++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached at cyc %0d, expected completion", cyc);
      $fatal(1, "watchdog");
   end

   int r0, s, s2, c, r2, c0, guard;
   int tk[5];
   int ev[5];
   int al[5];

   initial begin
      reset    = 1'b0;
      enable   = 1'b1;
      btn_up   = '0;
      btn_dn   = '0;
      recenter = 1'b0;

      // Reset values while reset is held
      wait_cyc(2);
      exp_coord(3, 202, 202, "rst_hold");
      exp_mov(3, 0, "rst_hold");
      exp_lim(3, 0, "rst_hold");

      // Release; ch0 up held from the release so the first tick is visible
      wait_cyc(4);
      r0 = 4;
      reset  = 1'b1;
      btn_up = 2'b01;
      exp_coord(r0+1, 202, 202, "rst_rel");
      exp_mov(r0+1, 0, "rst_rel");
      exp_lim(r0+1, 0, "rst_rel");
      exp_coord(r0+3, 202, 202, "pre_tick");
      exp_mov(r0+3, 1, "up_state");
      exp_coord(r0+4, 203, 202, "first_tick");
`ifdef PADDLE_ACCEL_EN
      exp_coord(r0+16, 206, 202, "accel_t4");
      exp_coord(r0+32, 214, 202, "accel_t8");
      exp_coord(r0+48, 226, 202, "accel_t12");
      exp_coord(r0+64, 242, 202, "accel_t16");
      wait_cyc(r0+64);
      btn_up = 2'b00;
      btn_dn = 2'b01;
      exp_mov(r0+67, 1, "reverse");
      exp_coord(r0+68, 241, 202, "reverse_t1");
      exp_coord(r0+72, 240, 202, "reverse_t2");
      wait_cyc(r0+72);
      btn_dn = 2'b00;
      exp_mov(r0+76, 0, "release");
      exp_coord(r0+76, 240, 202, "release");
      s  = r0 + 76;
      c0 = 240;
      tk = '{56, 57, 58, 59, 60};
      ev = '{2, 0, 0, 0, 0};
      al = '{0, 2, 2, 2, 2};
`else
      exp_coord(r0+40, 212, 202, "up10");
      exp_mov(r0+40, 1, "up10");
      wait_cyc(r0+40);
      btn_up = 2'b00;
      exp_mov(r0+43, 0, "release");
      exp_coord(r0+44, 212, 202, "release");
      s  = r0 + 44;
      c0 = 212;
      tk = '{199, 200, 201, 202, 203};
      ev = '{3, 2, 1, 0, 0};
      al = '{0, 0, 0, 2, 2};
`endif

      // ch1 down to the floor: saturates at 0, no wrap
      wait_cyc(s);
      btn_dn = 2'b10;
      for (int k = 0; k < 5; k++) begin
         push(s + 4*tk[k], 0, 1, ev[k], $sformatf("floor_t%0d.coord1", tk[k]));
         exp_lim(s + 4*tk[k], al[k], $sformatf("floor_t%0d", tk[k]));
      end
      exp_mov(s + 4*tk[4], 2, "floor");
      push(s + 4*tk[4], 0, 0, c0, "floor.coord0");
      wait_cyc(s + 4*tk[4]);
      btn_dn = 2'b00;
      s2 = s + 4*tk[4] + 4;

      // Both buttons on ch0: no movement; dropping dn resumes UP at step 1
      wait_cyc(s2);
      btn_up = 2'b01;
      btn_dn = 2'b01;
      exp_mov(s2+3, 0, "both");
      exp_coord(s2+20, c0, 0, "both_5ticks");
      exp_mov(s2+20, 0, "both_5ticks");
      wait_cyc(s2+20);
      btn_dn = 2'b00;
      exp_mov(s2+23, 1, "resume");
      exp_coord(s2+24, c0+1, 0, "resume_t1");
      exp_coord(s2+28, c0+2, 0, "resume_t2");
      wait_cyc(s2+28);
      btn_up = 2'b00;
      c0 = c0 + 2;
      c  = s2 + 32;

      // Recenter on a tick edge while both channels are moving
      wait_cyc(c);
      btn_up = 2'b01;
      btn_dn = 2'b10;
      exp_coord(c+8, c0+2, 0, "pre_recenter");
      exp_mov(c+8, 3, "pre_recenter");
      exp_lim(c+8, 2, "pre_recenter");
      wait_cyc(c+11);
      recenter = 1'b1;
      exp_coord(c+12, 202, 202, "recenter");
      exp_mov(c+12, 0, "recenter");
      exp_lim(c+12, 0, "recenter");
      wait_cyc(c+12);
      recenter = 1'b0;
      exp_mov(c+13, 3, "post_recenter");
      exp_coord(c+16, 203, 201, "post_recenter_t1");

      // Asynchronous reset between edges, mid-count
      wait_cyc(c+18);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_coord(c+19, 202, 202, "async_rst");
      exp_mov(c+19, 0, "async_rst");
      exp_lim(c+19, 0, "async_rst");
      wait_cyc(c+20);
      reset = 1'b1;
      r2 = c + 20;
      exp_coord(r2+3, 202, 202, "rst2_pre_tick");
      exp_mov(r2+3, 3, "rst2_state");
      exp_coord(r2+4, 203, 201, "rst2_first_tick");

      // enable low freezes the counter and coordinates
      wait_cyc(r2+5);
      enable = 1'b0;
      exp_coord(r2+8, 203, 201, "frozen");
      wait_cyc(r2+11);
      enable = 1'b1;
      exp_coord(r2+13, 203, 201, "resume_cnt");
      exp_coord(r2+14, 204, 200, "resume_tick");
      wait_cyc(r2+14);
      btn_up = '0;
      btn_dn = '0;
      wait_cyc(r2+20);

      guard = 0;
      while (sb.size() > 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
         n_fail += sb.size();
         n_run  += sb.size();
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/paddle_ctrl_multi.md
# paddle_ctrl_multi

Parametrised multi-channel paddle position controller for the Pong display pipeline. It converts per-player up/down button levels into saturating vertical paddle coordinates, one coordinate per channel. The coordinates feed the pixel generator and the collision logic. It replaces the single-paddle controller with a generated channel count, a configurable screen and paddle geometry, an internal movement tick, clamping at the limits with no bounce-back, recenter, and optional hold-to-accelerate.

## Interface
- NCH, 2: number of paddle channels.
- CW, 9: coordinate width in bits.
- RANGE, 480: visible vertical extent in lines.
- PH, 75: paddle height in lines.
- STEP, 1: base step, in lines per tick.
- MAXSTEP, 4: step ceiling when acceleration is compiled in.
- HOLD_TICKS, 16: consecutive same-direction ticks per step increment.
- TICK_DIV, 50000: clk cycles per movement tick.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  global run; when low, the tick counter and all coordinates hold.
- btn_up  in  NCH  debounced up level, one bit per channel.
- btn_dn  in  NCH  debounced down level, one bit per channel.
- recenter  in  1  synchronous; returns all paddles to CENTER.
- coord  out  NCH*CW  packed coordinates; channel i occupies bits [i*CW +: CW].
- moving  out  NCH  per-channel state != IDLE.
- at_limit  out  NCH  per-channel coord == 0 or coord == MAXC.

## Operation
- MAXC = RANGE-PH (405). CENTER = MAXC/2 (202). MAXC must fit in CW bits; this is checked at elaboration.
- Tick counter runs 0..TICK_DIV-1 while enable=1.
  - tick is a one-cycle pulse when the count equals TICK_DIV-1; the counter then wraps to 0.
- btn_up and btn_dn pass through a 2-flop synchronizer per bit.
- Per-channel FSM, updated every clk from the synchronized inputs:
  - IDLE: go to UP if up&!dn; go to DN if dn&!up.
  - UP / DN: go to IDLE on release or when both are pressed; go directly to the opposite state on reversal.
  - Any transition into UP or DN resets step to STEP and hold_cnt to 0.
- On tick, in UP: coord = min(coord+step, MAXC). In DN: coord = max(coord-step, 0).
  - Arithmetic is done in CW+1 bits. Coordinates saturate and never wrap.
- Both buttons pressed, or neither: no movement.
- recenter has the highest priority. It sets every coord to CENTER, resets step and hold_cnt, and forces IDLE. Movement on the same cycle is discarded.
- Reset values: coord=CENTER on all channels, moving=0, at_limit=0, tick counter=0, state=IDLE, step=STEP, hold_cnt=0.
- Channels are fully independent, except that they share the tick and recenter.

## Timing
- Button edge to FSM state change: 3 clk (2 synchronizer stages plus the state register).
- Button edge to first coord change: at most TICK_DIV+3 clk.
- coord is registered and updates on the tick edge.
- moving is registered. at_limit is combinational from the coord register.
- enable deasserted mid-count: the counter freezes and resumes from the same value.
- reset asserted at any time: outputs take their reset values immediately. The first tick comes TICK_DIV cycles after reset deassertion.

## Configuration
- PADDLE_ACCEL_EN defined: hold_cnt counts the ticks spent in the same state.
  - At HOLD_TICKS, step = min(step+1, MAXSTEP) and hold_cnt clears.
  - Saturation against 0 and MAXC still applies with the larger step.
- PADDLE_ACCEL_EN undefined: step is constant STEP. The hold_cnt and step registers are not built.

## Structure
- Shared package paddle_pkg holds:
  - the FSM state encoding (IDLE, UP, DN);
  - the CENTER/MAXC derivation functions;
  - the clog2 helper used to size the tick and hold counters.
- Sub-module paddle_axis holds one channel: synchronizer, FSM, step/hold logic and coord register.
- The top level holds the tick counter, the generate loop over NCH instances, and output packing.

## Test plan
All scenarios use TICK_DIV=4.
- Reset with reset=0, then release -> coord=202 on both channels, moving=0, at_limit=0; the first tick falls 4 cycles after release.
- Hold ch0 btn_up for 10 ticks, without acceleration -> ch0 coord=212, ch1 stays 202, moving=01b.
- Preload ch1 to 3 and hold btn_dn -> coord 2, 1, 0, 0, no wrap; at_limit[1]=1 from the tick that reaches 0.
- Assert btn_up and btn_dn together on ch0 -> no change over 5 ticks, moving[0]=0; releasing dn resumes UP with step=1.
- PADDLE_ACCEL_EN with HOLD_TICKS=4, MAXSTEP=4, holding up from 202 -> coord after ticks 4/8/12/16 reads 206/214/226/242; a reversal restores step 1.
- Pulse recenter mid-move, then pulse reset mid-count -> coord=202 in the next cycle and moving=0; reset zeroes the tick counter immediately.
